// File: rtl/core_ctrl_pkg.sv
// Control-word layout shared by the opcode decoder, the ID/EX register and the EX stage.
package core_ctrl_pkg;

    localparam int CTRL_W = 20;

    localparam int CTRL_RSVD      = 19;
    localparam int CTRL_LOAD      = 18;
    localparam int CTRL_WRE       = 17;
    localparam int CTRL_VWRE      = 16;
    localparam int CTRL_WME_A     = 15;
    localparam int CTRL_WME_B     = 14;
    localparam int CTRL_WB_HI     = 13;
    localparam int CTRL_WB_LO     = 12;
    localparam int CTRL_VWB_HI    = 11;
    localparam int CTRL_VWB_LO    = 10;
    localparam int CTRL_ALU_HI    = 9;
    localparam int CTRL_ALU_LO    = 5;
    localparam int CTRL_VALU_HI   = 4;
    localparam int CTRL_VALU_LO   = 0;

    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

    typedef struct packed {
        logic       rsvd;
        logic       load;
        logic       wre;
        logic       vector_wre;
        logic       wme_a;
        logic       wme_b;
        logic [1:0] wb_mux;
        logic [1:0] vector_wb_mux;
        logic [4:0] alu_op;
        logic [4:0] alu_vector_op;
    } ctrl_word_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the instruction in EX and the one being decoded.
module load_use_detect #(
    parameter int RADDR_W = 4
) (
    input  logic               i_ex_valid,
    input  logic               i_ex_load,
    input  logic               i_ex_wre,
    input  logic               i_ex_vwre,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic [RADDR_W-1:0] i_rs1,
    input  logic [RADDR_W-1:0] i_rs2,
    input  logic [1:0]         i_src_use,
    input  logic               i_vsrc,
    output logic               o_hazard
);

    logic w_domain_match;
    logic w_addr_match;

    // The load's destination file must be the file the ID sources read from.
    assign w_domain_match = (i_ex_wre & ~i_vsrc) | (i_ex_vwre & i_vsrc);
    assign w_addr_match   = (i_src_use[0] & (i_rs1 == i_ex_rd))
                          | (i_src_use[1] & (i_rs2 == i_ex_rd));
    assign o_hazard       = i_ex_valid & i_ex_load & w_domain_match & w_addr_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash and a saturating bubble counter.
module id_ex_stage_reg
    import core_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int VDATA_W = 128,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CTRL_W-1:0]  id_ctrl_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic [1:0]         id_src_use_i,
    input  logic               id_vsrc_i,
    input  logic [RADDR_W-1:0] id_rd_i,
    input  logic [DATA_W-1:0]  id_rs1_data_i,
    input  logic [DATA_W-1:0]  id_rs2_data_i,
    input  logic [VDATA_W-1:0] id_vs1_data_i,
    input  logic [VDATA_W-1:0] id_vs2_data_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic               stall_ext_i,
    input  logic               ex_branch_taken_i,
    output logic [CTRL_W-1:0]  ex_ctrl_o,
    output logic [RADDR_W-1:0] ex_rd_o,
    output logic [DATA_W-1:0]  ex_rs1_data_o,
    output logic [DATA_W-1:0]  ex_rs2_data_o,
    output logic [VDATA_W-1:0] ex_vs1_data_o,
    output logic [VDATA_W-1:0] ex_vs2_data_o,
    output logic [DATA_W-1:0]  ex_imm_o,
    output logic               ex_valid_o,
    output logic               stall_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    logic [CTRL_W-1:0]  r_ctrl;
    logic [RADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]  r_rs1_data;
    logic [DATA_W-1:0]  r_rs2_data;
    logic [VDATA_W-1:0] r_vs1_data;
    logic [VDATA_W-1:0] r_vs2_data;
    logic [DATA_W-1:0]  r_imm;
    logic               r_valid;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic               w_hazard;

    load_use_detect #(.RADDR_W(RADDR_W)) u_load_use_detect (
        .i_ex_valid (r_valid),
        .i_ex_load  (r_ctrl[CTRL_LOAD]),
        .i_ex_wre   (r_ctrl[CTRL_WRE]),
        .i_ex_vwre  (r_ctrl[CTRL_VWRE]),
        .i_ex_rd    (r_rd),
        .i_rs1      (id_rs1_i),
        .i_rs2      (id_rs2_i),
        .i_src_use  (id_src_use_i),
        .i_vsrc     (id_vsrc_i),
        .o_hazard   (w_hazard)
    );

    // A taken branch squashes the ID instruction, so there is nothing left to stall for.
    assign stall_o = w_hazard & ~ex_branch_taken_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl       <= NOP_CTRL;
            r_rd         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_vs1_data   <= '0;
            r_vs2_data   <= '0;
            r_imm        <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (ex_branch_taken_i || (!stall_ext_i && w_hazard)) begin
            r_ctrl     <= NOP_CTRL;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_vs1_data <= '0;
            r_vs2_data <= '0;
            r_imm      <= '0;
            r_valid    <= 1'b0;
            // Only load-use bubbles are counted, not branch squashes.
            if (!ex_branch_taken_i && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (!stall_ext_i) begin
            r_ctrl     <= id_ctrl_i;
            r_rd       <= id_rd_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
            r_vs1_data <= id_vs1_data_i;
            r_vs2_data <= id_vs2_data_i;
            r_imm      <= id_imm_i;
            r_valid    <= 1'b1;
        end
    end

    assign ex_ctrl_o     = r_ctrl;
    assign ex_rd_o       = r_rd;
    assign ex_rs1_data_o = r_rs1_data;
    assign ex_rs2_data_o = r_rs2_data;
    assign ex_vs1_data_o = r_vs1_data;
    assign ex_vs2_data_o = r_vs2_data;
    assign ex_imm_o      = r_imm;
    assign ex_valid_o    = r_valid;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg, built with a 2-bit bubble counter to reach saturation quickly.
module tb_id_ex_stage_reg;

    localparam int DATA_W  = 16;
    localparam int VDATA_W = 128;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 2;

    localparam logic [19:0] ADD  = 20'h2_0085;
    localparam logic [19:0] LDR  = 20'h6_0040;
    localparam logic [19:0] VLDR = 20'h5_0012;
    localparam logic [19:0] VADD = 20'h1_0003;

    typedef struct packed {
        logic [19:0]        ctrl;
        logic               valid;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  rs1d;
        logic [DATA_W-1:0]  rs2d;
        logic [VDATA_W-1:0] vs1;
        logic [VDATA_W-1:0] vs2;
        logic [DATA_W-1:0]  imm;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [19:0]        id_ctrl_i = '0;
    logic [RADDR_W-1:0] id_rs1_i = '0;
    logic [RADDR_W-1:0] id_rs2_i = '0;
    logic [1:0]         id_src_use_i = '0;
    logic               id_vsrc_i = 1'b0;
    logic [RADDR_W-1:0] id_rd_i = '0;
    logic [DATA_W-1:0]  id_rs1_data_i = '0;
    logic [DATA_W-1:0]  id_rs2_data_i = '0;
    logic [VDATA_W-1:0] id_vs1_data_i = '0;
    logic [VDATA_W-1:0] id_vs2_data_i = '0;
    logic [DATA_W-1:0]  id_imm_i = '0;
    logic               stall_ext_i = 1'b0;
    logic               ex_branch_taken_i = 1'b0;
    logic [19:0]        ex_ctrl_o;
    logic [RADDR_W-1:0] ex_rd_o;
    logic [DATA_W-1:0]  ex_rs1_data_o;
    logic [DATA_W-1:0]  ex_rs2_data_o;
    logic [VDATA_W-1:0] ex_vs1_data_o;
    logic [VDATA_W-1:0] ex_vs2_data_o;
    logic [DATA_W-1:0]  ex_imm_o;
    logic               ex_valid_o;
    logic               stall_o;
    logic [CNT_W-1:0]   bubble_cnt_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    exp_t a;

    id_ex_stage_reg #(
        .DATA_W (DATA_W),
        .VDATA_W(VDATA_W),
        .RADDR_W(RADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_ctrl_i        (id_ctrl_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_src_use_i     (id_src_use_i),
        .id_vsrc_i        (id_vsrc_i),
        .id_rd_i          (id_rd_i),
        .id_rs1_data_i    (id_rs1_data_i),
        .id_rs2_data_i    (id_rs2_data_i),
        .id_vs1_data_i    (id_vs1_data_i),
        .id_vs2_data_i    (id_vs2_data_i),
        .id_imm_i         (id_imm_i),
        .stall_ext_i      (stall_ext_i),
        .ex_branch_taken_i(ex_branch_taken_i),
        .ex_ctrl_o        (ex_ctrl_o),
        .ex_rd_o          (ex_rd_o),
        .ex_rs1_data_o    (ex_rs1_data_o),
        .ex_rs2_data_o    (ex_rs2_data_o),
        .ex_vs1_data_o    (ex_vs1_data_o),
        .ex_vs2_data_o    (ex_vs2_data_o),
        .ex_imm_o         (ex_imm_o),
        .ex_valid_o       (ex_valid_o),
        .stall_o          (stall_o),
        .bubble_cnt_o     (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // Operand payload is derived from a seed so every captured instruction is distinguishable.
    task automatic set_id(input logic [19:0] c, input logic [3:0] r1, input logic [3:0] r2,
                          input logic [1:0] su, input logic vs, input logic [3:0] rd,
                          input logic [15:0] s);
        id_ctrl_i     = c;
        id_rs1_i      = r1;
        id_rs2_i      = r2;
        id_src_use_i  = su;
        id_vsrc_i     = vs;
        id_rd_i       = rd;
        id_rs1_data_i = s;
        id_rs2_data_i = ~s;
        id_vs1_data_i = {8{s}};
        id_vs2_data_i = {8{s ^ 16'h00ff}};
        id_imm_i      = s + 16'h1;
    endtask

    function automatic exp_t cap(input logic [19:0] c, input logic [3:0] rd,
                                 input logic [15:0] s, input logic [CNT_W-1:0] cnt);
        exp_t x;
        x.ctrl  = c;
        x.valid = 1'b1;
        x.rd    = rd;
        x.rs1d  = s;
        x.rs2d  = ~s;
        x.vs1   = {8{s}};
        x.vs2   = {8{s ^ 16'h00ff}};
        x.imm   = s + 16'h1;
        x.cnt   = cnt;
        return x;
    endfunction

    function automatic exp_t bub(input logic [CNT_W-1:0] cnt);
        exp_t x;
        x     = '0;
        x.cnt = cnt;
        return x;
    endfunction

    function automatic exp_t sample();
        exp_t x;
        x = {ex_ctrl_o, ex_valid_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o,
             ex_vs1_data_o, ex_vs2_data_o, ex_imm_o, bubble_cnt_o};
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(ADD, 4'd1, 4'd2, 2'b11, 1'b0, 4'd5, 16'hbeef);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(bub(2'd0));
            step();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_%0d got %h want %h", i, a, e); end
        end
        reset = 1'b0;
        set_id(ADD, 4'd1, 4'd2, 2'b00, 1'b0, 4'd5, 16'h0101);
        #1; checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_reset got %b want 0", stall_o); end
        sb.push_back(cap(ADD, 4'd5, 16'h0101, 2'd0));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL first_add got %h want %h", a, e); end
    endtask

    task automatic test_scalar_load_use();
        set_id(LDR, 4'd1, 4'd2, 2'b01, 1'b0, 4'd3, 16'h0202);
        sb.push_back(cap(LDR, 4'd3, 16'h0202, 2'd0));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL ldr_capture got %h want %h", a, e); end
        set_id(ADD, 4'd3, 4'd2, 2'b01, 1'b0, 4'd4, 16'h0303);
        #1; checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_scalar_lu got %b want 1", stall_o); end
        sb.push_back(bub(2'd1));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL scalar_bubble got %h want %h", a, e); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_bubble got %b want 0", stall_o); end
        sb.push_back(cap(ADD, 4'd4, 16'h0303, 2'd1));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL add_after_bubble got %h want %h", a, e); end
    endtask

    task automatic test_domain();
        set_id(VLDR, 4'd1, 4'd2, 2'b00, 1'b1, 4'd3, 16'h0404);
        sb.push_back(cap(VLDR, 4'd3, 16'h0404, 2'd1));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL vldr_capture got %h want %h", a, e); end
        set_id(ADD, 4'd3, 4'd2, 2'b01, 1'b0, 4'd6, 16'h0505);
        #1; checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_domain_mismatch got %b want 0", stall_o); end
        sb.push_back(cap(ADD, 4'd6, 16'h0505, 2'd1));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL scalar_after_vldr got %h want %h", a, e); end
        set_id(VLDR, 4'd1, 4'd2, 2'b00, 1'b1, 4'd3, 16'h0606);
        sb.push_back(cap(VLDR, 4'd3, 16'h0606, 2'd1));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL vldr_capture2 got %h want %h", a, e); end
        set_id(VADD, 4'd5, 4'd3, 2'b10, 1'b1, 4'd7, 16'h0707);
        #1; checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_vector_lu got %b want 1", stall_o); end
        sb.push_back(bub(2'd2));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL vector_bubble got %h want %h", a, e); end
        sb.push_back(cap(VADD, 4'd7, 16'h0707, 2'd2));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL vadd_after_bubble got %h want %h", a, e); end
    endtask

    task automatic test_branch_flush();
        set_id(LDR, 4'd1, 4'd2, 2'b00, 1'b0, 4'd3, 16'h0808);
        sb.push_back(cap(LDR, 4'd3, 16'h0808, 2'd2));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL ldr_before_flush got %h want %h", a, e); end
        set_id(ADD, 4'd3, 4'd3, 2'b11, 1'b0, 4'd4, 16'h0909);
        ex_branch_taken_i = 1'b1;
        #1; checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_during_flush got %b want 0", stall_o); end
        sb.push_back(bub(2'd2));
        step();
        ex_branch_taken_i = 1'b0;
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL flush_bubble got %h want %h", a, e); end
        sb.push_back(cap(ADD, 4'd4, 16'h0909, 2'd2));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL add_after_flush got %h want %h", a, e); end
    endtask

    task automatic test_ext_stall();
        exp_t held;
        set_id(LDR, 4'd1, 4'd2, 2'b00, 1'b0, 4'd3, 16'h0a0a);
        held = cap(LDR, 4'd3, 16'h0a0a, 2'd2);
        sb.push_back(held);
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL ldr_before_stall got %h want %h", a, e); end
        stall_ext_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(ADD, 4'd3, 4'd2, 2'b01, 1'b0, 4'(4 + i), 16'(16'h1000 + i));
            #1; checks++;
            if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_ext_hazard_%0d got %b want 1", i, stall_o); end
            sb.push_back(held);
            step();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin errors++; $display("FAIL ext_hold_%0d got %h want %h", i, a, e); end
        end
        stall_ext_i = 1'b0;
        sb.push_back(bub(2'd3));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL bubble_after_ext got %h want %h", a, e); end
        sb.push_back(cap(ADD, 4'd6, 16'h1002, 2'd3));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL add_after_ext got %h want %h", a, e); end
    endtask

    task automatic test_saturation();
        int sat_tab [5] = '{1, 2, 3, 3, 3};
        reset = 1'b1;
        sb.push_back(bub(2'd0));
        step();
        reset = 1'b0;
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL sat_reset got %h want %h", a, e); end
        for (int k = 0; k < 5; k++) begin
            set_id(LDR, 4'd1, 4'd2, 2'b00, 1'b0, 4'd3, 16'(16'h2000 + k));
            sb.push_back(cap(LDR, 4'd3, 16'(16'h2000 + k), (k == 0) ? 2'd0 : 2'(sat_tab[k-1])));
            step();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin errors++; $display("FAIL sat_ldr_%0d got %h want %h", k, a, e); end
            set_id(ADD, 4'd3, 4'd2, 2'b01, 1'b0, 4'd4, 16'(16'h3000 + k));
            sb.push_back(bub(2'(sat_tab[k])));
            step();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin errors++; $display("FAIL sat_bubble_%0d got %h want %h", k, a, e); end
        end
    endtask

    task automatic test_mid_reset();
        set_id(LDR, 4'd1, 4'd2, 2'b00, 1'b0, 4'd3, 16'h4444);
        sb.push_back(cap(LDR, 4'd3, 16'h4444, 2'd3));
        step();
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL ldr_before_reset got %h want %h", a, e); end
        set_id(ADD, 4'd3, 4'd2, 2'b01, 1'b0, 4'd4, 16'h5555);
        reset = 1'b1;
        sb.push_back(bub(2'd0));
        step();
        reset = 1'b0;
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("FAIL mid_reset got %h want %h", a, e); end
    endtask

    initial begin
        test_reset();
        test_scalar_load_use();
        test_domain();
        test_branch_flush();
        test_ext_stall();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register placed directly downstream of the opcode decoder. Each cycle it captures the 20-bit control word, operands, destination and immediate for the EX stage. It detects load-use hazards and inserts a bubble while back-pressuring IF/ID. It also squashes the captured instruction on a taken bne and counts inserted bubbles.

Parameters:
DATA_W, 16, scalar operand/immediate width
VDATA_W, 128, vector operand width
RADDR_W, 4, register address width (scalar and vector files)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
id_ctrl_i  in  20  decoded control word from decoder
id_rs1_i  in  RADDR_W  source 1 address
id_rs2_i  in  RADDR_W  source 2 address
id_src_use_i  in  2  [0]=rs1 read, [1]=rs2 read
id_vsrc_i  in  1  1: sources index vector file, 0: scalar file
id_rd_i  in  RADDR_W  destination address
id_rs1_data_i, id_rs2_data_i  in  DATA_W  scalar operands
id_vs1_data_i, id_vs2_data_i  in  VDATA_W  vector operands
id_imm_i  in  DATA_W  immediate
stall_ext_i  in  1  global freeze (memory wait)
ex_branch_taken_i  in  1  bne resolved taken in EX
ex_ctrl_o  out  20  registered control word
ex_rd_o  out  RADDR_W  registered destination
ex_rs1_data_o, ex_rs2_data_o  out  DATA_W  registered scalar operands
ex_vs1_data_o, ex_vs2_data_o  out  VDATA_W  registered vector operands
ex_imm_o  out  DATA_W  registered immediate
ex_valid_o  out  1  1 = real instruction, 0 = bubble
stall_o  out  1  combinational; holds PC and IF/ID
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Control word layout: [19] reserved 0, [18] load, [17] wre, [16] vector_wre, [15] wme_a, [14] wme_b, [13:12] wb mux, [11:10] vector wb mux, [9:5] aluOp, [4:0] aluVectorOp. Bubble = all-zero word (nop).
- Reset: every output register is 0, ex_valid_o=0, bubble_cnt_o=0. Reset asserted mid-operation discards the captured instruction and the counter.
- Hazard (combinational): ex_valid_o & ex_ctrl_o[18] & dest-domain match & address match.
  - Dest domain is scalar if ex_ctrl_o[17], vector if ex_ctrl_o[16]; it must equal id_vsrc_i.
  - Address match: (id_src_use_i[0] & id_rs1_i==ex_rd_o) | (id_src_use_i[1] & id_rs2_i==ex_rd_o).
- stall_o = hazard & ~ex_branch_taken_i. No dependence on stall_ext_i.
- Update priority per cycle, highest first:
  1. reset
  2. ex_branch_taken_i: load bubble (ctrl=0, valid=0, data regs 0)
  3. stall_ext_i: hold all registers
  4. hazard: load bubble and increment counter
  5. otherwise: capture id_* and set ex_valid_o=1
- Latency: 1 cycle, id_* to ex_*.
- A load-use hazard produces exactly one bubble cycle. After it, the load has left EX, so the hazard clears without further state.
- A branch flush in the same cycle as a hazard: flush wins, stall_o=0, counter unchanged.
- stall_ext_i together with a hazard: hold, no counter increment. stall_o stays asserted.
- bubble_cnt_o saturates at all-ones; no wrap.
- An opcode that decodes to ctrl=0 is still captured with valid=1. It cannot create a hazard because load=0.

Decomposition:
- Package core_ctrl_pkg holds: the control-word bit-index constants, the CTRL_W=20 constant, NOP_CTRL='0, and a packed struct ctrl_word_t matching the layout above. The decoder and EX stage share it.
- One sub-module, load_use_detect: the purely combinational hazard compare, producing hazard.
- Registers and counter stay in id_ex_stage_reg.

Test Plan:
- Reset: hold reset 2 cycles with nonzero id_* → all outputs 0, valid=0, cnt=0. Then id_ctrl_i=20'h2_0085 (add) → ex_ctrl_o=20'h2_0085, valid=1 next cycle.
- Scalar load-use: EX holds ldr (ctrl=20'h6_0040, rd=3); ID add, rs1=3, src_use=01, vsrc=0 → stall_o=1. Next cycle ex_ctrl_o=0, valid=0, cnt=1. Cycle after, add captured.
- Domain mismatch: EX vldr (ctrl=20'h5_0012, rd=3); ID scalar add, rs1=3 → stall_o=0, no bubble. Repeat with vsrc=1 → bubble, cnt increments.
- Branch flush vs hazard: hazard conditions met and ex_branch_taken_i=1 in the same cycle → stall_o=0, bubble loaded, cnt unchanged.
- External stall: stall_ext_i=1 for 3 cycles while id_* changes → ex_* constant. With a concurrent hazard, stall_o=1 and cnt unchanged.
- Saturation with CNT_W=2: force 5 back-to-back hazards → cnt 1,2,3,3,3. Then reset mid-sequence → cnt=0 and valid=0 next cycle.
